// File: rtl/jtkicker_snd_pkg.sv
// jtkicker_snd_pkg: shared constants for the sound command channel
package jtkicker_snd_pkg;
  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_PULSE = 1;
  function automatic int lvl_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/jtkicker_sndcmd_mem.sv
// jtkicker_sndcmd_mem: command storage, one write port and one asynchronous read port
module jtkicker_sndcmd_mem #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [DW-1:0] i_wd,
  input  logic [AW-1:0] i_ra,
  output logic [DW-1:0] o_rd
);
  logic [DW-1:0] r_mem [0:2**AW-1];
  // storage is deliberately left unreset
  always_ff @(posedge clk)
    if (i_we) r_mem[i_wa] <= i_wd;
  assign o_rd = r_mem[i_ra];
endmodule

// File: rtl/jtkicker_sndcmd_fifo.sv
// jtkicker_sndcmd_fifo: main-to-sound command FIFO with IRQ generation and reply latch
module jtkicker_sndcmd_fifo
  import jtkicker_snd_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 2,
  parameter int IRQ_MODE = 1
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 m_wr,
  input  logic [DW-1:0]        m_din,
  output logic                 m_full,
  output logic                 m_ovf,
  input  logic                 m_rd,
  output logic [DW-1:0]        m_reply,
  output logic                 m_reply_new,
  input  logic                 s_rd,
  output logic [DW-1:0]        s_dout,
  output logic [lvl_w(AW)-1:0] s_level,
  input  logic                 s_wr,
  input  logic [DW-1:0]        s_din,
  input  logic                 s_flush,
  input  logic                 irq_ack,
  output logic                 int_n
);
  localparam int LW = lvl_w(AW);
  localparam logic [LW-1:0] DEPTH = LW'(1 << AW);
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level, w_level_nx;
  logic          r_srd_l, r_seen, w_pop, w_push, w_drop;
  logic [DW-1:0] w_head;

  jtkicker_sndcmd_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk  (clk),
    .i_we (w_push),
    .i_wa (r_wr_ptr),
    .i_wd (m_din),
    .i_ra (r_rd_ptr),
    .o_rd (w_head)
  );

  // pop on s_rd falling edge; a pop frees the slot for a same-cycle push when full
  always_comb begin
    w_pop      = r_srd_l & ~s_rd & (r_level != '0);
    w_push     = m_wr & ~s_flush & ((r_level != DEPTH) | w_pop);
    w_drop     = m_wr & ~s_flush & ~w_push;
    w_level_nx = s_flush ? '0 : r_level + LW'(w_push) - LW'(w_pop);
  end

  // pointers, level, full/overflow flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_srd_l  <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      m_full   <= 1'b0;
      m_ovf    <= 1'b0;
      r_seen   <= 1'b0;
    end else begin
      r_srd_l  <= s_rd;
      r_wr_ptr <= s_flush ? '0 : r_wr_ptr + AW'(w_push);
      r_rd_ptr <= s_flush ? '0 : r_rd_ptr + AW'(w_pop);
      r_level  <= w_level_nx;
      m_full   <= w_level_nx == DEPTH;
      m_ovf    <= ~s_flush & (m_ovf | w_drop);
      r_seen   <= r_seen | w_push;
    end

  // interrupt: level mode follows emptiness, pulse mode is set by push and cleared by ack
  always_ff @(posedge clk or posedge rst)
    if (rst) int_n <= 1'b1;
    else int_n <= IRQ_MODE == IRQ_LEVEL ? w_level_nx == '0
                                        : s_flush | (~w_push & (irq_ack | int_n));

  // reply latch; a write wins over a simultaneous read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_reply     <= '0;
      m_reply_new <= 1'b0;
    end else begin
      m_reply     <= s_wr ? s_din : m_reply;
      m_reply_new <= s_wr | (m_reply_new & ~m_rd);
    end

  assign s_level = r_level;
  assign s_dout  = r_seen ? w_head : '0;
endmodule
